// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store initiator between the core memory stage and a
// byte-addressable data RAM with a 32-bit big-endian read/write window.
// Sub-word stores are performed as read-modify-write of the window word.
module mem_access_unit #(
    parameter int MEM_BYTES = 12,
    parameter int RO_LIMIT  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] addr_bus,
    output logic [31:0] write_data_bus,
    output logic        write_signal,
    input  logic [31:0] read_data_bus
);

    localparam logic [32:0] MEM_END  = 33'(MEM_BYTES);
    localparam logic [31:0] BASE_MAX = 32'(MEM_BYTES - 4);
    localparam logic [31:0] RO_ADDR  = 32'(RO_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t      state_r;
    logic        write_r;
    logic [2:0]  funct3_r;
    logic [1:0]  lane_r;
    logic [15:0] wdata_r;

    logic [2:0]  size_s;
    logic        legal_s;
    logic        misaligned_s;
    logic        out_of_range_s;
    logic        read_only_s;
    logic        fault_s;
    logic [32:0] end_s;
    logic [32:0] win_end_s;
    logic [31:0] base_s;
    logic [1:0]  lane_s;

    // Extract the addressed byte/half from the window word and extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] aligned;
        aligned = word << {lane, 3'b000};
        case (f3)
            3'b000:  extend_load = {{24{aligned[31]}}, aligned[31:24]};
            3'b001:  extend_load = {{16{aligned[31]}}, aligned[31:16]};
            3'b100:  extend_load = {24'd0, aligned[31:24]};
            3'b101:  extend_load = {16'd0, aligned[31:16]};
            default: extend_load = word;
        endcase
    endfunction

    // Replace the target lane(s) of the window word with store data; f3[0] selects half.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane,
                                                input logic [15:0] wdata);
        logic [31:0] mask;
        logic [31:0] data;
        if (f3[0]) begin
            mask = 32'hFFFF_0000 >> {lane, 3'b000};
            data = {wdata, 16'h0000} >> {lane, 3'b000};
        end else begin
            mask = 32'hFF00_0000 >> {lane, 3'b000};
            data = {wdata[7:0], 24'h00_0000} >> {lane, 3'b000};
        end
        merge_store = (word & ~mask) | (data & mask);
    endfunction

    // Decode the incoming request: access size, fault checks and window placement.
    always_comb begin
        size_s  = 3'd4;
        legal_s = 1'b0;
        case (req_funct3)
            3'b000: begin size_s = 3'd1; legal_s = 1'b1;       end
            3'b001: begin size_s = 3'd2; legal_s = 1'b1;       end
            3'b010: begin size_s = 3'd4; legal_s = 1'b1;       end
            3'b100: begin size_s = 3'd1; legal_s = !req_write; end
            3'b101: begin size_s = 3'd2; legal_s = !req_write; end
            default: begin size_s = 3'd4; legal_s = 1'b0;      end
        endcase
        misaligned_s   = ((size_s == 3'd2) && req_addr[0]) ||
                         ((size_s == 3'd4) && (req_addr[1:0] != 2'd0));
        // 33-bit sums so addresses near the top of the space cannot wrap.
        end_s          = {1'b0, req_addr} + {30'd0, size_s};
        out_of_range_s = end_s > MEM_END;
        read_only_s    = req_write && (req_addr < RO_ADDR);
        fault_s        = !legal_s || misaligned_s || out_of_range_s || read_only_s;
        win_end_s      = {1'b0, req_addr} + 33'd4;
        if (win_end_s <= MEM_END) begin
            base_s = req_addr;
        end else begin
            base_s = BASE_MAX;
        end
        // Window offset is always 0..3, so the low two bits carry the difference.
        lane_s = req_addr[1:0] - base_s[1:0];
    end

    // Access sequencer: IDLE -> (RD) -> (WR) -> RESP, with registered bus and response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            write_r        <= 1'b0;
            funct3_r       <= 3'd0;
            lane_r         <= 2'd0;
            wdata_r        <= 16'd0;
            addr_bus       <= 32'd0;
            write_data_bus <= 32'd0;
            resp_rdata     <= 32'd0;
            resp_fault     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        addr_bus <= base_s;
                        write_r  <= req_write;
                        funct3_r <= req_funct3;
                        lane_r   <= lane_s;
                        wdata_r  <= req_wdata[15:0];
                        if (fault_s) begin
                            resp_rdata <= 32'd0;
                            resp_fault <= 1'b1;
                            state_r    <= RESP;
                        end else if (req_write && (req_funct3 == 3'b010)) begin
                            write_data_bus <= req_wdata;
                            state_r        <= WR;
                        end else begin
                            state_r <= RD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    if (write_r) begin
                        write_data_bus <= merge_store(read_data_bus, funct3_r, lane_r, wdata_r);
                        state_r        <= WR;
                    end else begin
                        resp_rdata <= extend_load(read_data_bus, funct3_r, lane_r);
                        resp_fault <= 1'b0;
                        state_r    <= RESP;
                    end
                end
                WR: begin
                    resp_rdata <= 32'd0;
                    resp_fault <= 1'b0;
                    state_r    <= RESP;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign req_ready    = (state_r == IDLE);
    assign resp_valid   = (state_r == RESP);
    assign write_signal = (state_r == WR);

endmodule
